// File: rtl/mbr_sequencer.sv
// Sequences one read or write transaction at a time through the memory buffer
// register and its single-port BRAM, driving the MBR strobes and memory pointer.
module mbr_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mbr_in,
  output logic              mbr_out,
  output logic              dram_in,
  output logic              dram_out,
  output logic [ADDR_W-1:0] pointer,
  output logic [DATA_W-1:0] bus_data,
  input  logic [DATA_W-1:0] mbr_data,
  output logic [2:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. Once raised, rsp_valid and rsp_rdata hold until that edge;
  // req_ready is high only while idle and never depends on req_valid.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STORE = 3'd2,
    ADDR  = 3'd3,
    CAPT  = 3'd4,
    OUT   = 3'd5,
    SAMP  = 3'd6,
    RESP  = 3'd7
  } state_t;

  // Last count value of the ADDR phase; the counter starts at 0 on entry.
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t     state;
  state_t     state_next;
  logic [2:0] lat_cnt;
  logic [2:0] lat_cnt_next;
  logic       accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign state_dbg = state;

  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next   = req_we ? LOAD : ADDR;
          lat_cnt_next = '0;
        end
      end
      LOAD:  state_next = STORE;
      STORE: state_next = RESP;
      ADDR: begin
        if (lat_cnt == LAT_LAST) begin
          state_next   = CAPT;
          lat_cnt_next = '0;
        end else begin
          lat_cnt_next = lat_cnt + 3'd1;
        end
      end
      CAPT: state_next = OUT;
      OUT:  state_next = SAMP;
      SAMP: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
    end
  end

  // Strobes and rsp_valid are decoded from the next state and registered, so
  // they are glitch-free and line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbr_in    <= 1'b0;
      dram_out  <= 1'b0;
      dram_in   <= 1'b0;
      mbr_out   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      mbr_in    <= (state_next == LOAD);
      dram_out  <= (state_next == STORE);
      dram_in   <= (state_next == CAPT);
      mbr_out   <= (state_next == OUT);
      rsp_valid <= (state_next == RESP);
    end
  end

  // Request fields are captured only on the accept edge; later input changes
  // cannot disturb an in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer  <= '0;
      bus_data <= '0;
    end else if (accept) begin
      pointer <= req_addr;
      if (req_we) begin
        bus_data <= req_wdata;
      end
    end
  end

  // The MBR output is valid during SAMP, one cycle after the mbr_out strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
    end else if (state == SAMP) begin
      rsp_rdata <= mbr_data;
    end
  end

endmodule

// File: tb/tb_mbr_sequencer.sv
// Bench for mbr_sequencer: two units (read latency 1 and 3), each with an MBR and
// BRAM model, checked against a transaction-level reference of memory contents and timing.
module tb_mbr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_we    [2];
  logic [3:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_rdata [2];
  logic       mbr_in    [2];
  logic       mbr_out   [2];
  logic       dram_in   [2];
  logic       dram_out  [2];
  logic [3:0] pointer   [2];
  logic [7:0] bus_data  [2];
  logic [2:0] state_dbg [2];

  int n_tests;
  int n_fail;

  // Reference model: memory image, last read value and last write data per unit
  logic [7:0] ref_mem [2][16];
  logic [7:0] last_rd [2];
  logic [7:0] exp_bus [2];
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs with MBR and BRAM environment models ----------------
  for (genvar g = 0; g < 2; g++) begin : unit
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] mem  [16];
    logic [7:0] pipe [8];
    logic [7:0] mbr_reg;
    logic [7:0] mbr_q;

    mbr_sequencer #(.ADDR_W(4), .DATA_W(8), .RD_LAT(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .mbr_in    (mbr_in[g]),
      .mbr_out   (mbr_out[g]),
      .dram_in   (dram_in[g]),
      .dram_out  (dram_out[g]),
      .pointer   (pointer[g]),
      .bus_data  (bus_data[g]),
      .mbr_data  (mbr_q),
      .state_dbg (state_dbg[g])
    );

    initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) pipe[i] = 8'h00;
      mbr_reg = 8'h00;
      mbr_q   = 8'h00;
    end

    // BRAM output appears L clocks after the pointer; MBR output register loads on mbr_out
    always @(posedge clk) begin
      pipe[0] <= mem[pointer[g]];
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      if (dram_out[g]) mem[pointer[g]] <= mbr_reg;
      if (mbr_in[g]) mbr_reg <= bus_data[g];
      else if (dram_in[g]) mbr_reg <= pipe[L-1];
      if (mbr_out[g]) mbr_q <= mbr_reg;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic scramble_req(input int u);
    req_valid[u] = 1'($urandom_range(0, 1));
    req_we[u]    = 1'($urandom_range(0, 1));
    req_addr[u]  = 4'($urandom);
    req_wdata[u] = 8'($urandom);
  endtask

  function automatic int strobe_sum(input int u);
    return int'(mbr_in[u]) + int'(mbr_out[u]) + int'(dram_in[u]) + int'(dram_out[u]);
  endfunction

  // Entered and left at a negedge with the unit idle.
  task automatic do_txn(input int u, input bit we, input logic [3:0] addr,
                        input logic [7:0] wdata, input int hold);
    int lat;
    int c;
    int c_mi, c_mo, c_di, c_do, c_rsp;
    int n_mi, n_mo, n_di, n_do;
    logic [7:0] exp_rd;
    lat = (u == 0) ? 1 : 3;
    if (we) begin
      ref_mem[u][addr] = wdata;
      exp_bus[u] = wdata;
      exp_rd = last_rd[u];
    end else begin
      exp_rd = ref_mem[u][addr];
      last_rd[u] = exp_rd;
    end
    exp_q.push_back(exp_rd);

    check("req_ready_idle", 32'(req_ready[u]), 1);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    rsp_ready[u] = 1'($urandom_range(0, 1));
    @(posedge clk);

    c = 0; c_rsp = 0;
    c_mi = 0; c_mo = 0; c_di = 0; c_do = 0;
    n_mi = 0; n_mo = 0; n_di = 0; n_do = 0;
    while (c_rsp == 0 && c < 40) begin
      @(negedge clk);
      c++;
      check("strobe_excl", 32'(strobe_sum(u) <= 1), 1);
      check("pointer_held", 32'(pointer[u]), 32'(addr));
      check("bus_data", 32'(bus_data[u]), 32'(exp_bus[u]));
      check("req_ready_busy", 32'(req_ready[u]), 0);
      if (mbr_in[u])   begin n_mi++; c_mi = c; end
      if (mbr_out[u])  begin n_mo++; c_mo = c; end
      if (dram_in[u])  begin n_di++; c_di = c; end
      if (dram_out[u]) begin n_do++; c_do = c; end
      if (rsp_valid[u]) begin
        c_rsp = c;
      end else begin
        scramble_req(u);
        rsp_ready[u] = 1'($urandom_range(0, 1));
      end
    end

    if (c_rsp == 0) begin
      check("rsp_timeout", 0, 1);
    end else if (we) begin
      check("w_mbr_in_cycle", c_mi, 1);
      check("w_dram_out_cycle", c_do, 2);
      check("w_rsp_cycle", c_rsp, 3);
      check("w_strobe_counts", n_mi * 10 + n_do, 11);
      check("w_no_read_strobes", n_di + n_mo, 0);
    end else begin
      check("r_dram_in_cycle", c_di, lat + 1);
      check("r_mbr_out_cycle", c_mo, lat + 2);
      check("r_rsp_cycle", c_rsp, lat + 4);
      check("r_strobe_counts", n_di * 10 + n_mo, 11);
      check("r_no_write_strobes", n_mi + n_do, 0);
    end
    check("rsp_rdata", 32'(rsp_rdata[u]), 32'(exp_q.pop_front()));

    scramble_req(u);
    rsp_ready[u] = (hold == 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[u]), 1);
      check("hold_rdata", 32'(rsp_rdata[u]), 32'(exp_rd));
      check("hold_req_ready", 32'(req_ready[u]), 0);
      check("hold_strobes", strobe_sum(u), 0);
      scramble_req(u);
      rsp_ready[u] = (k == hold - 1);
    end
    @(negedge clk);
    check("exit_valid", 32'(rsp_valid[u]), 0);
    check("exit_req_ready", 32'(req_ready[u]), 1);
    check("exit_rdata", 32'(rsp_rdata[u]), 32'(exp_rd));
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b0;
  endtask

  task automatic idle_gap(input int u);
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready[u]), 1);
    check("idle_rsp_valid", 32'(rsp_valid[u]), 0);
  endtask

  task automatic check_reset_state(input int u);
    check("rst_strobes", strobe_sum(u), 0);
    check("rst_rsp_valid", 32'(rsp_valid[u]), 0);
    check("rst_pointer", 32'(pointer[u]), 0);
    check("rst_bus_data", 32'(bus_data[u]), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata[u]), 0);
  endtask

  // Read on unit 0 (latency 1), reset asserted during its capture cycle.
  task automatic reset_mid_capt();
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 4'h3;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("capt_before_reset", 32'(dram_in[0]), 1);
    rst_n = 1'b0;
    #1;
    check_reset_state(0);
    check_reset_state(1);
    for (int u = 0; u < 2; u++) begin
      last_rd[u] = 8'h00;
      exp_bus[u] = 8'h00;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid[0]), 0);
      check("post_rst_req_ready", 32'(req_ready[0]), 1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_we[u]    = 1'b0;
      req_addr[u]  = 4'h0;
      req_wdata[u] = 8'h00;
      rsp_ready[u] = 1'b0;
      last_rd[u]   = 8'h00;
      exp_bus[u]   = 8'h00;
      for (int a = 0; a < 16; a++) ref_mem[u][a] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready[0]), 1);

    do_txn(0, 1'b1, 4'h3, 8'hAA, 0);
    do_txn(0, 1'b0, 4'h3, 8'h00, 0);
    do_txn(0, 1'b0, 4'h3, 8'h00, 4);
    do_txn(0, 1'b1, 4'hF, 8'h55, 0);
    do_txn(0, 1'b0, 4'hF, 8'h00, 0);
    do_txn(0, 1'b1, 4'h0, 8'h5A, 1);
    do_txn(0, 1'b0, 4'h0, 8'h00, 0);
    do_txn(0, 1'b1, 4'h7, 8'h12, 2);

    for (int i = 0; i < 40; i++) begin
      do_txn(0, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle_gap(0);
    end

    do_txn(1, 1'b0, 4'h0, 8'h00, 0);
    do_txn(1, 1'b1, 4'h0, 8'hC3, 0);
    do_txn(1, 1'b0, 4'h0, 8'h00, 2);
    do_txn(1, 1'b1, 4'hF, 8'h3C, 0);
    do_txn(1, 1'b0, 4'hF, 8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      do_txn(1, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle_gap(1);
    end

    reset_mid_capt();
    do_txn(0, 1'b0, 4'h3, 8'h00, 0);
    do_txn(0, 1'b1, 4'h9, 8'hE7, 1);
    do_txn(0, 1'b0, 4'h9, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
